// File: rtl/mem_port_arbiter_if.sv
// Request-side bundle (masters <-> arbiter) and single-port memory bundle (arbiter <-> memory).
// Grants are combinational and there is no buffering; an ungranted master simply holds its request.
interface mem_port_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16
);
  logic [NUM_MASTERS-1:0]              m_req;
  logic [NUM_MASTERS-1:0]              m_write_enable;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_address;
  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_write_data;
  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_byte_enable;
  logic [NUM_MASTERS-1:0]              m_gnt;
  logic [NUM_MASTERS-1:0]              m_rvalid;
  logic [DATA_WIDTH-1:0]               m_read_data;

  modport master (
    output m_req, m_write_enable, m_address, m_write_data, m_byte_enable,
    input  m_gnt, m_rvalid, m_read_data
  );

  modport slave (
    input  m_req, m_write_enable, m_address, m_write_data, m_byte_enable,
    output m_gnt, m_rvalid, m_read_data
  );
endinterface

interface mem_port_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                    mem_enable;
  logic                    mem_write_enable;
  logic [ADDR_WIDTH-1:0]   mem_address;
  logic [DATA_WIDTH-1:0]   mem_write_data;
  logic [DATA_WIDTH/8-1:0] mem_byte_enable;
  logic [DATA_WIDTH-1:0]   mem_read_data;

  modport master (
    output mem_enable, mem_write_enable, mem_address, mem_write_data, mem_byte_enable,
    input  mem_read_data
  );

  modport slave (
    input  mem_enable, mem_write_enable, mem_address, mem_write_data, mem_byte_enable,
    output mem_read_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_MASTERS; issue is same-cycle,
// read data returns READ_LATENCY cycles after grant. No request buffering: losers hold and retry.
module mem_port_arbiter #(
  parameter int NUM_MASTERS  = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  mem_port_arbiter_if.slave req,
  mem_port_if.master        mem
);
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int BE_W  = DATA_WIDTH / 8;

  logic [IDX_W-1:0] last_granted;
  logic [IDX_W-1:0] cand;
  logic             gnt_any;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_we;

  logic [READ_LATENCY-1:0]            pipe_vld;
  logic [READ_LATENCY-1:0][IDX_W-1:0] pipe_idx;

  // Search starts one past the last winner so every requester is served within NUM_MASTERS grants.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = IDX_W'((int'(last_granted) + k) % NUM_MASTERS);
      if (!gnt_any && req.m_req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (rst) begin
      gnt_any = 1'b0;
    end
  end

  always_comb begin
    req.m_gnt            = '0;
    gnt_we               = 1'b0;
    mem.mem_address      = '0;
    mem.mem_write_data   = '0;
    mem.mem_byte_enable  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_any && gnt_idx == IDX_W'(i)) begin
        req.m_gnt[i]        = 1'b1;
        gnt_we              = req.m_write_enable[i];
        mem.mem_address     = req.m_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem.mem_write_data  = req.m_write_data[i*DATA_WIDTH +: DATA_WIDTH];
        mem.mem_byte_enable = req.m_byte_enable[i*BE_W +: BE_W];
      end
    end
    mem.mem_enable       = gnt_any;
    mem.mem_write_enable = gnt_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_granted <= IDX_W'(NUM_MASTERS - 1);
      pipe_vld     <= '0;
      pipe_idx     <= '0;
    end else begin
      if (gnt_any) begin
        last_granted <= gnt_idx;
      end
      pipe_vld[0] <= gnt_any && !gnt_we;
      pipe_idx[0] <= gnt_idx;
      for (int s = 1; s < READ_LATENCY; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_idx[s] <= pipe_idx[s-1];
      end
    end
  end

  // Gating with rst keeps a read caught in the reset cycle from ever surfacing.
  always_comb begin
    req.m_rvalid = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      req.m_rvalid[i] = !rst && pipe_vld[READ_LATENCY-1] &&
                        (pipe_idx[READ_LATENCY-1] == IDX_W'(i));
    end
  end

  assign req.m_read_data = mem.mem_read_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Four arbiter configurations run in lockstep against a cycle-indexed reference model.
// Directed scenarios first, then constrained-random traffic with occasional resets.
module tb_mem_port_arbiter;
  localparam int NI = 4;
  localparam int NM  [NI] = '{2, 4, 3, 1};
  localparam int LAT [NI] = '{1, 3, 4, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_v [NI];
  logic [7:0]   req   [NI];
  logic [7:0]   we    [NI];
  logic [127:0] addr  [NI];
  logic [255:0] wd    [NI];
  logic [31:0]  be    [NI];
  logic [31:0]  mrd   [NI];

  logic [7:0]   gnt_o   [NI];
  logic [7:0]   rv_o    [NI];
  logic [31:0]  rd_o    [NI];
  logic         me_o    [NI];
  logic         mwe_o   [NI];
  logic [15:0]  maddr_o [NI];
  logic [31:0]  mwd_o   [NI];
  logic [3:0]   mbe_o   [NI];

  mem_port_arbiter_if #(.NUM_MASTERS(2), .DATA_WIDTH(32), .ADDR_WIDTH(16)) ra();
  mem_port_if         #(.DATA_WIDTH(32), .ADDR_WIDTH(16))                   ma();
  mem_port_arbiter #(.NUM_MASTERS(2), .DATA_WIDTH(32), .ADDR_WIDTH(16), .READ_LATENCY(1))
    u_a (.clk(clk), .rst(rst_v[0]), .req(ra.slave), .mem(ma.master));

  mem_port_arbiter_if #(.NUM_MASTERS(4), .DATA_WIDTH(32), .ADDR_WIDTH(16)) rb();
  mem_port_if         #(.DATA_WIDTH(32), .ADDR_WIDTH(16))                   mb();
  mem_port_arbiter #(.NUM_MASTERS(4), .DATA_WIDTH(32), .ADDR_WIDTH(16), .READ_LATENCY(3))
    u_b (.clk(clk), .rst(rst_v[1]), .req(rb.slave), .mem(mb.master));

  mem_port_arbiter_if #(.NUM_MASTERS(3), .DATA_WIDTH(32), .ADDR_WIDTH(16)) rc();
  mem_port_if         #(.DATA_WIDTH(32), .ADDR_WIDTH(16))                   mc();
  mem_port_arbiter #(.NUM_MASTERS(3), .DATA_WIDTH(32), .ADDR_WIDTH(16), .READ_LATENCY(4))
    u_c (.clk(clk), .rst(rst_v[2]), .req(rc.slave), .mem(mc.master));

  mem_port_arbiter_if #(.NUM_MASTERS(1), .DATA_WIDTH(32), .ADDR_WIDTH(16)) rd();
  mem_port_if         #(.DATA_WIDTH(32), .ADDR_WIDTH(16))                   md();
  mem_port_arbiter #(.NUM_MASTERS(1), .DATA_WIDTH(32), .ADDR_WIDTH(16), .READ_LATENCY(2))
    u_d (.clk(clk), .rst(rst_v[3]), .req(rd.slave), .mem(md.master));

  assign ra.m_req = req[0][1:0];  assign ra.m_write_enable = we[0][1:0];
  assign ra.m_address = addr[0][31:0];  assign ra.m_write_data = wd[0][63:0];
  assign ra.m_byte_enable = be[0][7:0];  assign ma.mem_read_data = mrd[0];
  assign gnt_o[0] = 8'(ra.m_gnt);  assign rv_o[0] = 8'(ra.m_rvalid);  assign rd_o[0] = ra.m_read_data;
  assign me_o[0] = ma.mem_enable;  assign mwe_o[0] = ma.mem_write_enable;  assign maddr_o[0] = ma.mem_address;
  assign mwd_o[0] = ma.mem_write_data;  assign mbe_o[0] = ma.mem_byte_enable;

  assign rb.m_req = req[1][3:0];  assign rb.m_write_enable = we[1][3:0];
  assign rb.m_address = addr[1][63:0];  assign rb.m_write_data = wd[1][127:0];
  assign rb.m_byte_enable = be[1][15:0];  assign mb.mem_read_data = mrd[1];
  assign gnt_o[1] = 8'(rb.m_gnt);  assign rv_o[1] = 8'(rb.m_rvalid);  assign rd_o[1] = rb.m_read_data;
  assign me_o[1] = mb.mem_enable;  assign mwe_o[1] = mb.mem_write_enable;  assign maddr_o[1] = mb.mem_address;
  assign mwd_o[1] = mb.mem_write_data;  assign mbe_o[1] = mb.mem_byte_enable;

  assign rc.m_req = req[2][2:0];  assign rc.m_write_enable = we[2][2:0];
  assign rc.m_address = addr[2][47:0];  assign rc.m_write_data = wd[2][95:0];
  assign rc.m_byte_enable = be[2][11:0];  assign mc.mem_read_data = mrd[2];
  assign gnt_o[2] = 8'(rc.m_gnt);  assign rv_o[2] = 8'(rc.m_rvalid);  assign rd_o[2] = rc.m_read_data;
  assign me_o[2] = mc.mem_enable;  assign mwe_o[2] = mc.mem_write_enable;  assign maddr_o[2] = mc.mem_address;
  assign mwd_o[2] = mc.mem_write_data;  assign mbe_o[2] = mc.mem_byte_enable;

  assign rd.m_req = req[3][0:0];  assign rd.m_write_enable = we[3][0:0];
  assign rd.m_address = addr[3][15:0];  assign rd.m_write_data = wd[3][31:0];
  assign rd.m_byte_enable = be[3][3:0];  assign md.mem_read_data = mrd[3];
  assign gnt_o[3] = 8'(rd.m_gnt);  assign rv_o[3] = 8'(rd.m_rvalid);  assign rd_o[3] = rd.m_read_data;
  assign me_o[3] = md.mem_enable;  assign mwe_o[3] = md.mem_write_enable;  assign maddr_o[3] = md.mem_address;
  assign mwd_o[3] = md.mem_write_data;  assign mbe_o[3] = md.mem_byte_enable;

  // Reference state: round-robin pointer and a read-return table indexed by cycle number mod 8.
  int ptr    [NI];
  int sched  [NI][8];
  int last_g [NI];
  int cyc;
  int n_checks;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      int g;
      int s;
      g = -1;
      if (!rst_v[k]) begin
        for (int j = 1; j <= NM[k]; j++) begin
          int c;
          c = (ptr[k] + j) % NM[k];
          if (g < 0 && req[k][c]) g = c;
        end
      end
      last_g[k] = g;
      chk($sformatf("gnt%0d", k), 32'(gnt_o[k]), (g >= 0) ? (32'd1 << g) : 32'd0);
      chk($sformatf("mem_en%0d", k), 32'(me_o[k]), (g >= 0) ? 32'd1 : 32'd0);
      if (g >= 0) begin
        chk($sformatf("mem_we%0d", k), 32'(mwe_o[k]), 32'(we[k][g]));
        chk($sformatf("mem_addr%0d", k), 32'(maddr_o[k]), 32'(addr[k][g*16 +: 16]));
        chk($sformatf("mem_wd%0d", k), mwd_o[k], wd[k][g*32 +: 32]);
        chk($sformatf("mem_be%0d", k), 32'(mbe_o[k]), 32'(be[k][g*4 +: 4]));
      end else begin
        chk($sformatf("idle_we%0d", k), 32'(mwe_o[k]), 32'd0);
        chk($sformatf("idle_be%0d", k), 32'(mbe_o[k]), 32'd0);
      end
      s = rst_v[k] ? -1 : sched[k][cyc % 8];
      chk($sformatf("rvalid%0d", k), 32'(rv_o[k]), (s >= 0) ? (32'd1 << s) : 32'd0);
      if (s >= 0) chk($sformatf("rdata%0d", k), rd_o[k], mrd[k]);
    end
  endtask

  task automatic advance();
    for (int k = 0; k < NI; k++) begin
      if (rst_v[k]) begin
        ptr[k] = NM[k] - 1;
        for (int j = 0; j < 8; j++) sched[k][j] = -1;
      end else begin
        sched[k][cyc % 8] = -1;
        if (last_g[k] >= 0) begin
          ptr[k] = last_g[k];
          if (!we[k][last_g[k]]) sched[k][(cyc + LAT[k]) % 8] = last_g[k];
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NI; k++) mrd[k] = $urandom;
  endtask

  task automatic drop(input int k);
    if (last_g[k] >= 0) req[k][last_g[k]] = 1'b0;
  endtask

  // A master that is still waiting keeps its fields; a fresh slot may draw a new request.
  task automatic rand_step(input int k);
    for (int i = 0; i < NM[k]; i++) begin
      if (!(req[k][i] && last_g[k] != i)) begin
        req[k][i]            = 1'($urandom_range(0, 1));
        we[k][i]             = 1'($urandom_range(0, 1));
        addr[k][i*16 +: 16]  = 16'($urandom);
        wd[k][i*32 +: 32]    = $urandom;
        be[k][i*4 +: 4]      = 4'($urandom);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    for (int k = 0; k < NI; k++) begin
      rst_v[k]  = 1'b1;
      req[k]    = '0;
      we[k]     = '0;
      addr[k]   = {$urandom, $urandom, $urandom, $urandom};
      wd[k]     = {8{$urandom}};
      be[k]     = $urandom;
      mrd[k]    = $urandom;
      ptr[k]    = NM[k] - 1;
      last_g[k] = -1;
      for (int j = 0; j < 8; j++) sched[k][j] = -1;
    end

    repeat (2) begin
      sample();
      for (int k = 0; k < NI; k++) begin
        chk("rst_gnt", 32'(gnt_o[k]), 32'd0);
        chk("rst_rvalid", 32'(rv_o[k]), 32'd0);
        chk("rst_mem_en", 32'(me_o[k]), 32'd0);
      end
      advance();
    end
    for (int k = 0; k < NI; k++) rst_v[k] = 1'b0;

    // First grants after reset: two reads, latency 1.
    req[0] = 8'b11; we[0] = 8'b00;
    sample(); chk("first_c0_gnt", 32'(gnt_o[0]), 32'h1); advance(); drop(0);
    sample(); chk("first_c1_gnt", 32'(gnt_o[0]), 32'h2);
    chk("first_c1_rvalid", 32'(rv_o[0]), 32'h1); advance(); drop(0);
    sample(); chk("first_c2_rvalid", 32'(rv_o[0]), 32'h2);
    chk("first_c2_gnt", 32'(gnt_o[0]), 32'h0); advance();

    // Idle stretch must leave the pointer where the last grant put it.
    req[0] = 8'b01;
    sample(); chk("idle_pre_gnt", 32'(gnt_o[0]), 32'h1); advance(); drop(0);
    repeat (10) begin
      sample(); chk("idle_mem_en", 32'(me_o[0]), 32'h0); advance();
    end
    req[0] = 8'b11;
    sample(); chk("idle_ptr_kept", 32'(gnt_o[0]), 32'h2); advance(); drop(0);
    sample(); chk("idle_then_m0", 32'(gnt_o[0]), 32'h1); advance(); drop(0);

    // Partial-lane write, then a write with no lanes enabled.
    req[0] = 8'b01; we[0] = 8'b01;
    addr[0][15:0] = 16'h0004; wd[0][31:0] = 32'hA5A5A5A5; be[0][3:0] = 4'b0011;
    sample();
    chk("wr_mem_en", 32'(me_o[0]), 32'h1);
    chk("wr_mem_we", 32'(mwe_o[0]), 32'h1);
    chk("wr_mem_addr", 32'(maddr_o[0]), 32'h0004);
    chk("wr_mem_be", 32'(mbe_o[0]), 32'h3);
    chk("wr_mem_wd", mwd_o[0], 32'hA5A5A5A5);
    advance(); drop(0);
    repeat (3) begin
      sample(); chk("wr_no_rvalid", 32'(rv_o[0]), 32'h0); advance();
    end
    req[0] = 8'b01; be[0][3:0] = 4'b0000;
    sample();
    chk("wr_zero_be_en", 32'(me_o[0]), 32'h1);
    chk("wr_zero_be_be", 32'(mbe_o[0]), 32'h0);
    advance(); drop(0);
    we[0] = 8'b00;

    // Fairness with four masters requesting every cycle.
    req[1] = 8'hF; we[1] = 8'h0;
    for (int i = 0; i < 8; i++) begin
      sample(); chk($sformatf("fair_%0d", i), 32'(gnt_o[1]), 32'd1 << (i % 4)); advance();
    end
    req[1] = 8'h0;

    // Latency-3 read: returned data is whatever memory presents three cycles on.
    req[1] = 8'b0010; addr[1][31:16] = 16'h0010;
    sample();
    chk("lat3_gnt", 32'(gnt_o[1]), 32'h2);
    chk("lat3_addr", 32'(maddr_o[1]), 32'h0010);
    advance(); drop(1);
    repeat (2) begin sample(); advance(); end
    mrd[1] = 32'hDEADBEEF;
    sample();
    chk("lat3_rvalid", 32'(rv_o[1]), 32'h2);
    chk("lat3_rdata", rd_o[1], 32'hDEADBEEF);
    advance();

    // Reset two cycles after a latency-4 read; the read must vanish.
    req[2] = 8'b010; we[2] = 8'b000;
    sample(); chk("rstmid_gnt", 32'(gnt_o[2]), 32'h2); advance(); drop(2);
    sample(); advance();
    rst_v[2] = 1'b1;
    sample(); chk("rstmid_gnt_in_rst", 32'(gnt_o[2]), 32'h0); advance();
    rst_v[2] = 1'b0;
    repeat (6) begin
      sample(); chk("rstmid_no_rvalid", 32'(rv_o[2]), 32'h0); advance();
    end
    req[2] = 8'b111;
    sample(); chk("rstmid_next_m0", 32'(gnt_o[2]), 32'h1); advance(); drop(2);
    req[2] = 8'b000;

    // Single master granted every requesting cycle.
    req[3] = 8'b1;
    for (int i = 0; i < 5; i++) begin
      sample(); chk($sformatf("single_%0d", i), 32'(gnt_o[3]), 32'h1); advance();
    end
    req[3] = 8'b0;

    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < NI; k++) begin
        rand_step(k);
        rst_v[k] = ($urandom_range(0, 63) == 0);
      end
      sample();
      advance();
    end
    for (int k = 0; k < NI; k++) begin
      rst_v[k] = 1'b0;
      req[k]   = '0;
    end
    repeat (6) begin sample(); advance(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_MASTERS, default 2, meaning number of requesting masters, legal range 1..8.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning data bus width in bits, a multiple of 8.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 16, meaning address width in bits.
REQ-004 The block SHALL have parameter READ_LATENCY, default 1, meaning memory cycles from read issue to read data valid, legal range 1..4.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port m_req, input, NUM_MASTERS bits: per-master access request.
REQ-008 The block SHALL have port m_write_enable, input, NUM_MASTERS bits: per-master access type, 1 = write, 0 = read.
REQ-009 The block SHALL have port m_address, input, NUM_MASTERS*ADDR_WIDTH bits: per-master address, master i in slice i.
REQ-010 The block SHALL have port m_write_data, input, NUM_MASTERS*DATA_WIDTH bits: per-master write data.
REQ-011 The block SHALL have port m_byte_enable, input, NUM_MASTERS*DATA_WIDTH/8 bits: per-master byte lanes.
REQ-012 The block SHALL have port m_gnt, output, NUM_MASTERS bits: one-hot grant, access issued this cycle.
REQ-013 The block SHALL have port m_rvalid, output, NUM_MASTERS bits: one-hot read data valid for the owning master.
REQ-014 The block SHALL have port m_read_data, output, DATA_WIDTH bits: read data, shared by all masters, qualified by m_rvalid.
REQ-015 The block SHALL have the memory-side ports mem_enable (out, 1), mem_write_enable (out, 1), mem_address (out, ADDR_WIDTH), mem_write_data (out, DATA_WIDTH), mem_byte_enable (out, DATA_WIDTH/8) and mem_read_data (in, DATA_WIDTH), matching the team's single-port memory master modport.

Function
REQ-016 Each cycle, the block SHALL grant at most one requesting master, combinationally, using round-robin priority starting at (last_granted+1) mod NUM_MASTERS.
REQ-017 The block SHALL update last_granted only in cycles with a grant; a cycle with no request SHALL leave it unchanged.
REQ-018 In a grant cycle, the block SHALL drive mem_enable=1 and route the granted master's write_enable, address, write_data and byte_enable to the mem_* outputs in the same cycle.
REQ-019 With no grant, the block SHALL drive mem_enable=0, mem_write_enable=0 and mem_byte_enable=0.
REQ-020 A master SHALL hold m_req and its request fields stable until it sees m_gnt; the block SHALL NOT buffer ungranted requests.
REQ-021 For a granted read, the block SHALL assert m_rvalid[i] for exactly one cycle, exactly READ_LATENCY cycles after the grant cycle, with m_read_data = mem_read_data in that cycle.
REQ-022 The block SHALL track in-flight reads in a READ_LATENCY-deep shift pipeline of {valid, master index}; back-to-back reads, one per cycle, SHALL be supported with no bubbles.
REQ-023 Granted writes SHALL produce no m_rvalid.
REQ-024 A write with all byte enables zero SHALL still be granted and issued with mem_enable=1.
REQ-025 When NUM_MASTERS=1, a request SHALL be granted every cycle it is asserted.
REQ-026 When m_rvalid is all-zero, m_read_data SHALL be don't-care; the verification bench SHALL NOT check it.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL set last_granted to NUM_MASTERS-1, so master 0 has highest priority, and SHALL clear all in-flight pipeline entries.
REQ-028 While rst=1, m_gnt, m_rvalid, mem_enable, mem_write_enable and mem_byte_enable SHALL all be 0.
REQ-029 Reads in flight when rst is asserted SHALL never produce m_rvalid, including after rst deasserts.

Verification
REQ-030 Scenario, first grant after reset (N=2, LAT=1): after reset, m_req=2'b11, both reads -> cycle0 m_gnt=01; cycle1 m_gnt=10 with m_rvalid=01; cycle2 m_rvalid=10.
REQ-031 Scenario, fairness (N=4): all masters request continuously -> grants 0,1,2,3,0,... with no master granted twice before the others.
REQ-032 Scenario, latency (LAT=3): master1 reads address 0x0010 while mem_read_data is driven 0xDEADBEEF three cycles later -> m_rvalid=0010 and m_read_data=0xDEADBEEF exactly 3 cycles after the grant.
REQ-033 Scenario, write: master0 writes 0xA5A5A5A5 to 0x0004 with byte_enable=4'b0011 -> same cycle mem_enable=1, mem_write_enable=1, mem_address=0x0004, mem_byte_enable=0011; no m_rvalid follows.
REQ-034 Scenario, reset mid-operation (LAT=4): issue a read, assert rst for 1 cycle two cycles later -> no m_rvalid ever; the next grant goes to master 0.
REQ-035 Scenario, idle: m_req=0 for 10 cycles -> mem_enable=0 throughout, and the round-robin pointer is unchanged on the next request.
